// File: rtl/cpi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpi_pkg
//  Description : Shared types and default widths for the CPI request-layer
//                link manager (link-state encoding, request beat layout).
//  Revision    : 1.0 - initial release
// ============================================================================
package cpi_pkg;

  localparam int CPI_HDR_W = 128;
  localparam int CPI_PID_W = 4;

  typedef enum logic [1:0] {
    IDLE          = 2'd0,
    CONNECTED     = 2'd1,
    DISCONNECTING = 2'd2,
    FATAL         = 2'd3
  } cpi_link_state_e;

  typedef struct packed {
    logic [CPI_PID_W-1:0] pid;
    logic [CPI_HDR_W-1:0] header;
  } cpi_req_t;

  // States in which the agent sees its connect request acknowledged.
  function automatic logic link_acked(input cpi_link_state_e s);
    return (s == CONNECTED) || (s == DISCONNECTING);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpi_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : cpi_sync_fifo
//  Description : Single-clock FIFO with show-ahead read data, flush, and
//                wrap-bit pointers for full/empty detection. A push into a
//                full FIFO is accepted when a pop happens in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpi_sync_fifo #(
  parameter int WIDTH = 132,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  // Pointer update; flush and reset both return the FIFO to empty.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (!rst && !flush && push_ok) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule
`default_nettype wire

// File: rtl/cpi_req_link_mgr.sv
`default_nettype none
// ============================================================================
//  Module      : cpi_req_link_mgr
//  Description : Agent-side CPI global-layer connect/disconnect FSM with a
//                buffered, credit-throttled A2F->F2A request path, disconnect
//                NACK while traffic drains, sticky fatal and error flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpi_req_link_mgr
  import cpi_pkg::*;
#(
  parameter int HDR_W    = CPI_HDR_W,
  parameter int PID_W    = CPI_PID_W,
  parameter int DEPTH    = 8,
  parameter int CRD_INIT = 4
) (
  input  logic             fm_clk,
  input  logic             fm_rst,
  input  logic             a2f_txcon_req,
  output logic             a2f_rxcon_ack,
  output logic             a2f_rxdiscon_nack,
  output logic             a2f_rx_empty,
  input  logic             a2f_fatal,
  input  logic             a2f_req_is_valid,
  input  logic [PID_W-1:0] a2f_req_protocol_id,
  input  logic [HDR_W-1:0] a2f_req_header,
  output logic             f2a_req_is_valid,
  output logic [PID_W-1:0] f2a_req_protocol_id,
  output logic [HDR_W-1:0] f2a_req_header,
  input  logic             f2a_req_crd_rtn,
  output logic             f2a_fatal,
  output logic             err_overflow,
  output logic             err_protocol
);

  localparam int              CW      = $clog2(CRD_INIT + 1);
  localparam int              DW      = PID_W + HDR_W;
  localparam logic [CW-1:0]   CRD_MAX = CW'(CRD_INIT);

  cpi_link_state_e state;
  logic [CW-1:0]   crd;
  logic [DW-1:0]   head;
  logic            fifo_full;
  logic            fifo_empty;
  logic            push_req;
  logic            push_ok;
  logic            pop;
  logic            flush;

  // A fatal beat flushes immediately so the FIFO reads empty in FATAL.
  assign flush        = a2f_fatal || (state == FATAL);
  assign pop          = !fifo_empty && (crd != '0) && (state != FATAL) && !a2f_fatal;
  assign push_req     = a2f_req_is_valid && (state == CONNECTED) && !a2f_fatal;
  assign push_ok      = push_req && (!fifo_full || pop);
  assign a2f_rx_empty = fifo_empty;

  cpi_sync_fifo #(
    .WIDTH (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (fm_clk),
    .rst   (fm_rst),
    .push  (push_req),
    .pop   (pop),
    .flush (flush),
    .wdata ({a2f_req_protocol_id, a2f_req_header}),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Link FSM with registered ack/nack/fatal outputs; fatal overrides all.
  always_ff @(posedge fm_clk) begin
    if (fm_rst) begin
      state             <= IDLE;
      a2f_rxcon_ack     <= 1'b0;
      a2f_rxdiscon_nack <= 1'b0;
      f2a_fatal         <= 1'b0;
    end else if (a2f_fatal || (state == FATAL)) begin
      state             <= FATAL;
      a2f_rxcon_ack     <= 1'b0;
      a2f_rxdiscon_nack <= 1'b0;
      f2a_fatal         <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (a2f_txcon_req) begin
            state         <= CONNECTED;
            a2f_rxcon_ack <= 1'b1;
          end
        end
        CONNECTED: begin
          // A beat accepted this cycle counts as pending traffic.
          if (!a2f_txcon_req) begin
            if (fifo_empty && !push_ok) begin
              state         <= IDLE;
              a2f_rxcon_ack <= 1'b0;
            end else begin
              state             <= DISCONNECTING;
              a2f_rxdiscon_nack <= 1'b1;
            end
          end
        end
        DISCONNECTING: begin
          if (a2f_txcon_req) begin
            state             <= CONNECTED;
            a2f_rxdiscon_nack <= 1'b0;
          end else if (fifo_empty) begin
            state             <= IDLE;
            a2f_rxcon_ack     <= 1'b0;
            a2f_rxdiscon_nack <= 1'b0;
          end
        end
        default: begin
          state <= state;
        end
      endcase
    end
  end

  // Credit counter: a pop and a return in the same cycle cancel out.
  always_ff @(posedge fm_clk) begin
    if (fm_rst) begin
      crd <= CRD_MAX;
    end else if (pop && !f2a_req_crd_rtn) begin
      crd <= crd - CW'(1);
    end else if (!pop && f2a_req_crd_rtn && (crd < CRD_MAX)) begin
      crd <= crd + CW'(1);
    end
  end

  // Forwarded request: one-cycle valid per pop, payload holds otherwise.
  always_ff @(posedge fm_clk) begin
    if (fm_rst) begin
      f2a_req_is_valid    <= 1'b0;
      f2a_req_protocol_id <= '0;
      f2a_req_header      <= '0;
    end else begin
      f2a_req_is_valid <= pop;
      if (pop) begin
        f2a_req_protocol_id <= head[DW-1:HDR_W];
        f2a_req_header      <= head[HDR_W-1:0];
      end
    end
  end

  // Sticky drop flags; beats arriving with or after a fatal drop silently.
  always_ff @(posedge fm_clk) begin
    if (fm_rst) begin
      err_overflow <= 1'b0;
      err_protocol <= 1'b0;
    end else begin
      if (push_req && fifo_full && !pop) err_overflow <= 1'b1;
      if (a2f_req_is_valid && !a2f_fatal && (state != FATAL) && !link_acked(state)) err_protocol <= 1'b1;
      if (a2f_req_is_valid && !a2f_fatal && (state == DISCONNECTING)) err_protocol <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: doc/cpi_req_link_mgr.md
Name: cpi_req_link_mgr

Overview:
Parametrised successor to the fabric manager's A2F connect logic. Runs a full CPI global-layer connect/disconnect FSM for the agent side. Buffers A2F request-layer packets in a DEPTH-entry FIFO and forwards them to the F2A request layer under credit flow control. Adds disconnect NACK while traffic is pending, sticky fatal handling and error flags; sits between the agent CPI port and the fabric in the CXL memory path.

Parameters:
HDR_W, 128, request header width in bits
PID_W, 4, protocol-id width in bits
DEPTH, 8, request FIFO entries (power of two, >=2)
CRD_INIT, 4, F2A request credits loaded at reset (1..15)

Ports:
fm_clk  in  1  clock; all logic on posedge
fm_rst  in  1  synchronous active-high reset
a2f_txcon_req  in  1  agent connect request (level)
a2f_rxcon_ack  out  1  connect acknowledge (level)
a2f_rxdiscon_nack  out  1  disconnect refused while traffic pending
a2f_rx_empty  out  1  request FIFO empty
a2f_fatal  in  1  agent fatal error
a2f_req_is_valid  in  1  request beat valid
a2f_req_protocol_id  in  PID_W  request protocol id
a2f_req_header  in  HDR_W  request header
f2a_req_is_valid  out  1  forwarded request valid (1-cycle pulse per packet)
f2a_req_protocol_id  out  PID_W  forwarded protocol id
f2a_req_header  out  HDR_W  forwarded header
f2a_req_crd_rtn  in  1  fabric returns one request credit (pulse)
f2a_fatal  out  1  sticky fatal indication to fabric
err_overflow  out  1  sticky: request dropped, FIFO full
err_protocol  out  1  sticky: request dropped, link not CONNECTED

Behaviour:
- Interface decision: one clock, fm_clk; reset fm_rst is synchronous and active-high.
- Reset: all outputs 0 except a2f_rx_empty=1. FIFO pointers 0, credits=CRD_INIT, FSM=IDLE.
- Reset mid-operation discards FIFO contents and clears the sticky flags.
- FSM states: IDLE, CONNECTED, DISCONNECTING, FATAL.
  - IDLE: a2f_txcon_req=1 -> CONNECTED. a2f_rxcon_ack=1 from the next cycle, so ack latency is 1 cycle.
  - CONNECTED: txcon_req=0 with FIFO empty -> IDLE, ack=0 next cycle. txcon_req=0 with FIFO non-empty -> DISCONNECTING.
  - DISCONNECTING: ack stays 1; a2f_rxdiscon_nack=1 every cycle in this state.
    - FIFO becomes empty -> IDLE, ack=0, nack=0 next cycle.
    - txcon_req reasserts -> CONNECTED, nack=0 next cycle.
  - FATAL: entered from any state when a2f_fatal=1 (highest priority).
    - Next cycle: ack=0, nack=0, f2a_fatal=1, FIFO flushed (rx_empty=1), f2a_req_is_valid=0.
    - Only fm_rst exits FATAL.
- Enqueue: a2f_req_is_valid=1 in CONNECTED writes {protocol_id, header} into the FIFO.
  - If FIFO full: beat dropped, err_overflow set.
  - In IDLE or DISCONNECTING: beat dropped, err_protocol set.
  - In FATAL: silently dropped.
- Dequeue: when FIFO non-empty, credits>0 and state is not FATAL, pop one entry per cycle.
  - Drive it on f2a_req_* the next cycle with f2a_req_is_valid=1 for exactly one cycle.
  - Consume one credit per pop.
  - Forwarding continues in DISCONNECTING; this drain is what clears the NACK.
- Minimum FIFO latency: a write at cycle N can be popped at N+1 and appears on f2a_req_* at N+2.
- Simultaneous push and pop when full: the pop frees a slot, so the push is accepted (no overflow).
- Credit counter: width $clog2(CRD_INIT+1).
  - Pop and crd_rtn in the same cycle: count unchanged.
  - crd_rtn with count already CRD_INIT: ignored, saturates.
- a2f_rx_empty is combinational from the FIFO pointers; pointers carry an extra wrap bit for full/empty detection.
- f2a_req_protocol_id and f2a_req_header hold their last value when valid=0.

Decomposition:
- Shared package cpi_pkg:
  - typedef enum cpi_link_state_e {IDLE, CONNECTED, DISCONNECTING, FATAL}.
  - Default widths CPI_HDR_W=128 and CPI_PID_W=4.
  - Packed struct cpi_req_t {pid, header}.
- One sub-module: cpi_sync_fifo, a parametrised WIDTH/DEPTH FIFO with push, pop, flush, full and empty.
- FSM, credit counter and error flags stay in the top module.

Test Plan:
- Connect/disconnect: raise txcon_req at cycle 10 -> ack=1 at 11. Drop it at 20 with FIFO empty -> ack=0 at 21, nack never 1.
- Credit throttle (CRD_INIT=4, DEPTH=8): push 6 requests with headers 0x1..0x6 -> exactly 4 f2a pulses in order 0x1..0x4, rx_empty=0. Two crd_rtn pulses -> 0x5 and 0x6 forwarded, rx_empty=1.
- Disconnect NACK: with 3 queued and credits=0, drop txcon_req -> nack=1 and ack=1 held. Return 3 credits -> 3 pulses, then nack=0 and ack=0 one cycle after empty.
- Overflow: with credits=0, push 9 beats into DEPTH=8 -> err_overflow=1 on the 9th. FIFO holds headers 1..8 only.
- Push/pop when full: FIFO full with credits=1, push and pop in the same cycle -> no overflow, occupancy stays 8.
- Fatal and reset: a2f_fatal at mid-traffic -> next cycle ack=0, f2a_fatal=1, rx_empty=1, no further f2a pulses even after crd_rtn and txcon_req. fm_rst=1 for one cycle -> all outputs at reset values, credits=4.
